// File: rtl/sdram_init_cfg.sv
// SDRAM power-up initialisation sequencer. It issues PRECHARGE ALL, AR_NUM AUTO REFRESH,
// MRS and an optional EMRS, then holds END until a re-init request arrives.
module sdram_init_cfg #(
   parameter int unsigned ADDR_W       = 13,
   parameter int unsigned BANK_W       = 2,
   parameter int unsigned T_POWER      = 20000,
   parameter int unsigned T_RP         = 2,
   parameter int unsigned T_RFC        = 7,
   parameter int unsigned T_MRD        = 2,
   parameter int unsigned AR_NUM       = 2,
   parameter logic [31:0] MODE_REG     = 32'h0000_0037,
   parameter bit          EMRS_EN      = 1'b1,
   parameter logic [31:0] EXT_MODE_REG = 32'h0000_0000,
   parameter logic [31:0] EMRS_BANK    = 32'h0000_0002
) (
   input  logic              init_clk,
   input  logic              init_rst_n,
   input  logic              init_req,
   output logic [3:0]        init_cmd,
   output logic [BANK_W-1:0] init_bank,
   output logic [ADDR_W-1:0] init_addr,
   output logic              init_end
);

   localparam int unsigned CNT_W = $clog2(T_POWER + 1);
   localparam int unsigned AR_W  = $clog2(AR_NUM + 1);

   localparam logic [3:0] CMD_NOP = 4'b0111;
   localparam logic [3:0] CMD_PRE = 4'b0010;
   localparam logic [3:0] CMD_AR  = 4'b0001;
   localparam logic [3:0] CMD_MRS = 4'b0000;

   localparam logic [3:0] S_IDLE  = 4'd0;
   localparam logic [3:0] S_PRE   = 4'd1;
   localparam logic [3:0] S_TRP   = 4'd2;
   localparam logic [3:0] S_AR    = 4'd3;
   localparam logic [3:0] S_TRFC  = 4'd4;
   localparam logic [3:0] S_MRS   = 4'd5;
   localparam logic [3:0] S_TMRD  = 4'd6;
   localparam logic [3:0] S_EMRS  = 4'd7;
   localparam logic [3:0] S_TEMRD = 4'd8;
   localparam logic [3:0] S_END   = 4'd9;

   localparam logic [ADDR_W-1:0] ADDR_PRE_ALL = ADDR_W'(32'h0000_0400);
   localparam logic [ADDR_W-1:0] ADDR_MODE    = ADDR_W'(MODE_REG);
   localparam logic [ADDR_W-1:0] ADDR_EXT     = ADDR_W'(EXT_MODE_REG);
   localparam logic [BANK_W-1:0] BANK_EXT     = BANK_W'(EMRS_BANK);

   logic [3:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [AR_W-1:0]   ar_q, ar_d;
   logic [3:0]        cmd_q, cmd_d;
   logic [BANK_W-1:0] bank_q, bank_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              end_q, end_d;

   // Next state, then outputs decoded from the next state so they are registered alongside it.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ar_d    = ar_q;
      cmd_d   = CMD_NOP;
      bank_d  = '0;
      addr_d  = '0;
      end_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (cnt_q == CNT_W'(T_POWER - 1)) begin
               state_d = S_PRE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_PRE: begin
            state_d = S_TRP;
            cnt_d   = '0;
         end
         S_TRP: begin
            if (cnt_q == CNT_W'(T_RP - 1)) begin
               state_d = S_AR;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_AR: begin
            state_d = S_TRFC;
            cnt_d   = '0;
            ar_d    = ar_q + AR_W'(1);
         end
         S_TRFC: begin
            if (cnt_q == CNT_W'(T_RFC - 1)) begin
               cnt_d = '0;
               if (ar_q < AR_W'(AR_NUM)) begin
                  state_d = S_AR;
               end else begin
                  state_d = S_MRS;
                  ar_d    = '0;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_MRS: begin
            state_d = S_TMRD;
            cnt_d   = '0;
         end
         S_TMRD: begin
            if (cnt_q == CNT_W'(T_MRD - 1)) begin
               state_d = EMRS_EN ? S_EMRS : S_END;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_EMRS: begin
            state_d = S_TEMRD;
            cnt_d   = '0;
         end
         S_TEMRD: begin
            if (cnt_q == CNT_W'(T_MRD - 1)) begin
               state_d = S_END;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_END: begin
            // Re-init skips the power-up wait.
            if (init_req) begin
               state_d = S_PRE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            ar_d    = '0;
         end
      endcase

      case (state_d)
         S_PRE: begin
            cmd_d  = CMD_PRE;
            addr_d = ADDR_PRE_ALL;
         end
         S_AR:  cmd_d = CMD_AR;
         S_MRS: begin
            cmd_d  = CMD_MRS;
            addr_d = ADDR_MODE;
         end
         S_EMRS: begin
            cmd_d  = CMD_MRS;
            addr_d = ADDR_EXT;
            bank_d = BANK_EXT;
         end
         S_END:   end_d = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge init_clk or negedge init_rst_n) begin
      if (!init_rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         ar_q    <= '0;
         cmd_q   <= CMD_NOP;
         bank_q  <= '0;
         addr_q  <= '0;
         end_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ar_q    <= ar_d;
         cmd_q   <= cmd_d;
         bank_q  <= bank_d;
         addr_q  <= addr_d;
         end_q   <= end_d;
      end
   end

   assign init_cmd  = cmd_q;
   assign init_bank = bank_q;
   assign init_addr = addr_q;
   assign init_end  = end_q;

endmodule

// File: tb/tb_sdram_init_cfg.sv
// Bench for sdram_init_cfg: two configurations (with EMRS, and without EMRS / four refreshes)
// compared each cycle against a command-schedule model.
module tb_sdram_init_cfg;

   localparam int TP   = 10;
   localparam int TRP  = 2;
   localparam int TRFC = 3;
   localparam int TMRD = 2;
   localparam int LEN_A = TP + 1 + TRP + 2 * (1 + TRFC) + 1 + TMRD + 1 + TMRD;
   localparam int LEN_B = TP + 1 + TRP + 4 * (1 + TRFC) + 1 + TMRD;

   localparam logic [22:0] NOP_E = {1'b0, 4'b0111, 2'b00, 16'h0000};
   localparam logic [22:0] PRE_E = {1'b0, 4'b0010, 2'b00, 16'h0400};
   localparam logic [22:0] AR_E  = {1'b0, 4'b0001, 2'b00, 16'h0000};
   localparam logic [22:0] END_E = {1'b1, 4'b0111, 2'b00, 16'h0000};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, req;
   logic [3:0]  cmd_a, cmd_b;
   logic [1:0]  bank_a, bank_b;
   logic [12:0] addr_a;
   logic [11:0] addr_b;
   logic        end_a, end_b;

   int errors = 0;
   int checks = 0;
   int pos_a, pos_b;
   logic [22:0] obs_a, obs_b, exp_a, exp_b;

   sdram_init_cfg #(
      .ADDR_W(13), .BANK_W(2), .T_POWER(TP), .T_RP(TRP), .T_RFC(TRFC), .T_MRD(TMRD),
      .AR_NUM(2), .MODE_REG(32'h0000_0037), .EMRS_EN(1'b1),
      .EXT_MODE_REG(32'h0000_0020), .EMRS_BANK(32'h0000_0002)
   ) dut_a (
      .init_clk(clk), .init_rst_n(rst_n), .init_req(req),
      .init_cmd(cmd_a), .init_bank(bank_a), .init_addr(addr_a), .init_end(end_a)
   );

   sdram_init_cfg #(
      .ADDR_W(12), .BANK_W(2), .T_POWER(TP), .T_RP(TRP), .T_RFC(TRFC), .T_MRD(TMRD),
      .AR_NUM(4), .MODE_REG(32'h0002_0237), .EMRS_EN(1'b0),
      .EXT_MODE_REG(32'h0000_0055), .EMRS_BANK(32'h0000_0002)
   ) dut_b (
      .init_clk(clk), .init_rst_n(rst_n), .init_req(req),
      .init_cmd(cmd_b), .init_bank(bank_b), .init_addr(addr_b), .init_end(end_b)
   );

   // Model: position within the command schedule; END is any position at or past its length.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pos_a <= 0;
         pos_b <= 0;
      end else begin
         if (pos_a >= LEN_A) begin
            if (req) pos_a <= TP;
         end else pos_a <= pos_a + 1;
         if (pos_b >= LEN_B) begin
            if (req) pos_b <= TP;
         end else pos_b <= pos_b + 1;
      end
   end

   function automatic logic [22:0] exp_at(input int pos, input int ar_num, input bit emrs,
                                          input logic [15:0] mode, input logic [15:0] emode);
      int p;
      p = pos;
      if (p < TP) return NOP_E;
      p -= TP;
      if (p == 0) return PRE_E;
      p -= 1;
      if (p < TRP) return NOP_E;
      p -= TRP;
      for (int i = 0; i < ar_num; i++) begin
         if (p == 0) return AR_E;
         p -= 1;
         if (p < TRFC) return NOP_E;
         p -= TRFC;
      end
      if (p == 0) return {1'b0, 4'b0000, 2'b00, mode};
      p -= 1;
      if (p < TMRD) return NOP_E;
      p -= TMRD;
      if (emrs) begin
         if (p == 0) return {1'b0, 4'b0000, 2'b10, emode};
         p -= 1;
         if (p < TMRD) return NOP_E;
      end
      return END_E;
   endfunction

   task automatic test_reset();
      rst_n = 1'b1;
      req   = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      for (int c = 0; c < 3; c++) begin
         checks++;
         if ({end_a, cmd_a, bank_a, addr_a} !== {1'b0, 4'b0111, 2'b00, 13'h0}) begin
            errors++;
            $display("FAIL reset_a c=%0d got %h want %h", c, {end_a, cmd_a, bank_a, addr_a},
                     {1'b0, 4'b0111, 2'b00, 13'h0});
         end
         checks++;
         if ({end_b, cmd_b, bank_b, addr_b} !== {1'b0, 4'b0111, 2'b00, 12'h0}) begin
            errors++;
            $display("FAIL reset_b c=%0d got %h want %h", c, {end_b, cmd_b, bank_b, addr_b},
                     {1'b0, 4'b0111, 2'b00, 12'h0});
         end
         @(negedge clk);
      end
   endtask

   task automatic test_power_up();
      rst_n = 1'b1;
      for (int c = 0; c < 36; c++) begin
         obs_a = {end_a, cmd_a, bank_a, 3'b000, addr_a};
         obs_b = {end_b, cmd_b, bank_b, 4'b0000, addr_b};
         exp_a = exp_at(pos_a, 2, 1'b1, 16'h0037, 16'h0020);
         exp_b = exp_at(pos_b, 4, 1'b0, 16'h0237, 16'h0000);
         checks += 2;
         if (obs_a !== exp_a) begin
            errors++;
            $display("FAIL power_up_a c=%0d got %h want %h", c, obs_a, exp_a);
         end
         if (obs_b !== exp_b) begin
            errors++;
            $display("FAIL power_up_b c=%0d got %h want %h", c, obs_b, exp_b);
         end
         if (c == 10) begin
            checks++;
            if (cmd_a !== 4'b0010 || addr_a !== 13'h400) begin
               errors++;
               $display("FAIL pre_at_10 got cmd=%b addr=%h want cmd=0010 addr=400", cmd_a, addr_a);
            end
         end
         if (c == 24) begin
            checks++;
            if (cmd_a !== 4'b0000 || bank_a !== 2'b10) begin
               errors++;
               $display("FAIL emrs_at_24 got cmd=%b bank=%b want cmd=0000 bank=10", cmd_a, bank_a);
            end
         end
         if (c == 26 || c == 27) begin
            checks++;
            if (end_a !== (c == 27)) begin
               errors++;
               $display("FAIL end_a_at_%0d got %b want %b", c, end_a, c == 27);
            end
         end
         if (c == 29) begin
            checks++;
            if (cmd_b !== 4'b0000 || addr_b !== 12'h237) begin
               errors++;
               $display("FAIL mrs_b_at_29 got cmd=%b addr=%h want cmd=0000 addr=237", cmd_b, addr_b);
            end
         end
         if (c == 31 || c == 32) begin
            checks++;
            if (end_b !== (c == 32)) begin
               errors++;
               $display("FAIL end_b_at_%0d got %b want %b", c, end_b, c == 32);
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reinit();
      for (int c = 0; c < 24; c++) begin
         obs_a = {end_a, cmd_a, bank_a, 3'b000, addr_a};
         obs_b = {end_b, cmd_b, bank_b, 4'b0000, addr_b};
         exp_a = exp_at(pos_a, 2, 1'b1, 16'h0037, 16'h0020);
         exp_b = exp_at(pos_b, 4, 1'b0, 16'h0237, 16'h0000);
         checks += 2;
         if (obs_a !== exp_a) begin
            errors++;
            $display("FAIL reinit_a c=%0d got %h want %h", c, obs_a, exp_a);
         end
         if (obs_b !== exp_b) begin
            errors++;
            $display("FAIL reinit_b c=%0d got %h want %h", c, obs_b, exp_b);
         end
         if (c == 1) begin
            checks++;
            if (end_a !== 1'b0 || cmd_a !== 4'b0010) begin
               errors++;
               $display("FAIL reinit_pre got end=%b cmd=%b want end=0 cmd=0010", end_a, cmd_a);
            end
         end
         req = (c == 0);
         @(negedge clk);
      end
      req = 1'b0;
   endtask

   task automatic test_reset_mid();
      for (int c = 0; c < 16; c++) begin
         obs_a = {end_a, cmd_a, bank_a, 3'b000, addr_a};
         exp_a = exp_at(pos_a, 2, 1'b1, 16'h0037, 16'h0020);
         checks++;
         if (obs_a !== exp_a) begin
            errors++;
            $display("FAIL reset_mid_pre_a c=%0d got %h want %h", c, obs_a, exp_a);
         end
         @(negedge clk);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({end_a, cmd_a, bank_a, addr_a} !== {1'b0, 4'b0111, 2'b00, 13'h0}) begin
         errors++;
         $display("FAIL reset_mid_async got %h want %h", {end_a, cmd_a, bank_a, addr_a},
                  {1'b0, 4'b0111, 2'b00, 13'h0});
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 30; c++) begin
         obs_a = {end_a, cmd_a, bank_a, 3'b000, addr_a};
         obs_b = {end_b, cmd_b, bank_b, 4'b0000, addr_b};
         exp_a = exp_at(pos_a, 2, 1'b1, 16'h0037, 16'h0020);
         exp_b = exp_at(pos_b, 4, 1'b0, 16'h0237, 16'h0000);
         checks += 2;
         if (obs_a !== exp_a) begin
            errors++;
            $display("FAIL reset_mid_a c=%0d got %h want %h", c, obs_a, exp_a);
         end
         if (obs_b !== exp_b) begin
            errors++;
            $display("FAIL reset_mid_b c=%0d got %h want %h", c, obs_b, exp_b);
         end
         if (c == 9 || c == 10) begin
            checks++;
            if ((cmd_a === 4'b0010) !== (c == 10)) begin
               errors++;
               $display("FAIL restart_pre c=%0d got cmd=%b want pre=%b", c, cmd_a, c == 10);
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_req_held();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 36; c++) begin
         obs_a = {end_a, cmd_a, bank_a, 3'b000, addr_a};
         obs_b = {end_b, cmd_b, bank_b, 4'b0000, addr_b};
         // Outside END the request is ignored, so the full power-up schedule applies.
         exp_a = exp_at(c, 2, 1'b1, 16'h0037, 16'h0020);
         exp_b = exp_at(c, 4, 1'b0, 16'h0237, 16'h0000);
         checks += 2;
         if (obs_a !== exp_a) begin
            errors++;
            $display("FAIL req_held_a c=%0d got %h want %h", c, obs_a, exp_a);
         end
         if (obs_b !== exp_b) begin
            errors++;
            $display("FAIL req_held_b c=%0d got %h want %h", c, obs_b, exp_b);
         end
         req = (c >= 5 && c <= 20);
         @(negedge clk);
      end
      req = 1'b0;
   endtask

   task automatic test_random();
      int hold;
      hold = 0;
      for (int c = 0; c < 1500; c++) begin
         obs_a = {end_a, cmd_a, bank_a, 3'b000, addr_a};
         obs_b = {end_b, cmd_b, bank_b, 4'b0000, addr_b};
         exp_a = exp_at(pos_a, 2, 1'b1, 16'h0037, 16'h0020);
         exp_b = exp_at(pos_b, 4, 1'b0, 16'h0237, 16'h0000);
         checks += 2;
         if (obs_a !== exp_a) begin
            errors++;
            $display("FAIL random_a c=%0d got %h want %h", c, obs_a, exp_a);
         end
         if (obs_b !== exp_b) begin
            errors++;
            $display("FAIL random_b c=%0d got %h want %h", c, obs_b, exp_b);
         end
         req = ($urandom_range(0, 7) == 0);
         if (hold > 0) begin
            hold--;
            if (hold == 0) rst_n = 1'b1;
         end else if ($urandom_range(0, 149) == 0) begin
            rst_n = 1'b0;
            hold  = int'($urandom_range(1, 3));
            #1;
            checks++;
            if ({end_a, cmd_a, end_b, cmd_b} !== {1'b0, 4'b0111, 1'b0, 4'b0111}) begin
               errors++;
               $display("FAIL random_async_rst c=%0d got %h want %h", c,
                        {end_a, cmd_a, end_b, cmd_b}, {1'b0, 4'b0111, 1'b0, 4'b0111});
            end
         end
         @(negedge clk);
      end
      rst_n = 1'b1;
      req   = 1'b0;
   endtask

   initial begin
      test_reset();
      test_power_up();
      test_reinit();
      test_reset_mid();
      test_req_held();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
